// File: rtl/sfa_xbar_switch.sv
// sfa_xbar_switch: N-input / M-output AXI-Stream crossbar with per-output
// 2-entry slices and drain-before-apply run-time routing via a config stream.
// Ports:
//   ACLK, ARESETN             clock, asynchronous active-low reset
//   s_tvalid/s_tready/s_tdata N_IN slave streams, input i at [i*DATA_W +: DATA_W]
//   m_tvalid/m_tready/m_tdata N_OUT master streams, output j at [j*DATA_W +: DATA_W]
//   cfg_tvalid/cfg_tready     config word stream; cfg_tdata[7:0] output,
//   cfg_tdata                 [15:8] input select, [16] enable
//   cfg_busy                  high while a word is draining/applying
//   cfg_err                   sticky out-of-range config flag
module sfa_xbar_switch #(
   parameter int DATA_W = 32,
   parameter int N_IN   = 4,
   parameter int N_OUT  = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic [N_IN-1:0]         s_tvalid,
   output logic [N_IN-1:0]         s_tready,
   input  logic [N_IN*DATA_W-1:0]  s_tdata,
   output logic [N_OUT-1:0]        m_tvalid,
   input  logic [N_OUT-1:0]        m_tready,
   output logic [N_OUT*DATA_W-1:0] m_tdata,
   input  logic                    cfg_tvalid,
   output logic                    cfg_tready,
   input  logic [31:0]             cfg_tdata,
   output logic                    cfg_busy,
   output logic                    cfg_err
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] APPLY = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              err_q, err_d;
   logic              load;
   logic              cfg_ok;
   logic              idx_empty;
   logic [7:0]        idx_q;
   logic [SEL_W-1:0]  sel_q;
   logic              en_q;
   logic [N_OUT-1:0]  route_en_q, blocked_q, slice_rdy, push, pop, empty;
   logic [SEL_W-1:0]  route_sel_q [N_OUT];
   logic [DATA_W-1:0] in_data [N_IN];
   logic [N_IN-1:0]   has_dst, all_rdy;
   logic              unused_cfg;

   assign unused_cfg = ^cfg_tdata[31:17];

   for (genvar i = 0; i < N_IN; i++) begin : g_in
      assign in_data[i] = s_tdata[i*DATA_W +: DATA_W];
   end

   // An input is ready only when it has at least one destination and every
   // destination slice can take the beat, so broadcasts are all-or-nothing.
   always_comb begin
      has_dst = '0;
      all_rdy = '1;
      for (int i = 0; i < N_IN; i++)
         for (int j = 0; j < N_OUT; j++)
            if (route_en_q[j] && route_sel_q[j] == SEL_W'(i)) begin
               has_dst[i] = 1'b1;
               all_rdy[i] = all_rdy[i] & slice_rdy[j];
            end
   end
   assign s_tready = has_dst & all_rdy;

   for (genvar j = 0; j < N_OUT; j++) begin : g_out
      logic [1:0]        cnt_q, cnt_d;
      logic [DATA_W-1:0] head_q, tail_q;
      assign slice_rdy[j] = cnt_q != 2'd2 && !blocked_q[j];
      assign push[j]      = route_en_q[j] && s_tvalid[route_sel_q[j]] && s_tready[route_sel_q[j]];
      assign pop[j]       = cnt_q != 2'd0 && m_tready[j];
      assign empty[j]     = cnt_q == 2'd0;
      assign cnt_d        = cnt_q + {1'b0, push[j]} - {1'b0, pop[j]};
      assign m_tvalid[j]  = !empty[j];
      assign m_tdata[j*DATA_W +: DATA_W] = head_q;
      // Push into a full slice cannot happen: slice_rdy excludes count 2.
      always_ff @(posedge ACLK or negedge ARESETN) begin
         if (!ARESETN) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
         end else begin
            cnt_q <= cnt_d;
            if (pop[j] && cnt_q == 2'd2)
               head_q <= tail_q;
            else if (push[j] && (cnt_q == 2'd0 || pop[j]))
               head_q <= in_data[route_sel_q[j]];
            if (push[j] && cnt_q == 2'd1 && !pop[j])
               tail_q <= in_data[route_sel_q[j]];
         end
      end
   end

   assign cfg_ok = int'(cfg_tdata[7:0]) < N_OUT && int'(cfg_tdata[15:8]) < N_IN;

   always_comb begin
      idx_empty = 1'b0;
      for (int j = 0; j < N_OUT; j++)
         if (idx_q == 8'(j)) idx_empty = empty[j];
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      load    = 1'b0;
      if (state_q == IDLE && cfg_tvalid) begin
         if (cfg_ok) begin
            load    = 1'b1;
            state_d = DRAIN;
         end else
            err_d = 1'b1;
      end else if (state_q == DRAIN && idx_empty)
         state_d = APPLY;
      else if (state_q != IDLE && state_q != DRAIN)
         state_d = IDLE;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= IDLE;
         err_q      <= 1'b0;
         idx_q      <= '0;
         sel_q      <= '0;
         en_q       <= 1'b0;
         route_en_q <= '0;
         blocked_q  <= '0;
         for (int j = 0; j < N_OUT; j++) route_sel_q[j] <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (load) begin
            idx_q <= cfg_tdata[7:0];
            sel_q <= cfg_tdata[8 +: SEL_W];
            en_q  <= cfg_tdata[16];
         end
         // Blocking the target output stops new pushes so its slice can drain.
         for (int j = 0; j < N_OUT; j++) begin
            if (load && cfg_tdata[7:0] == 8'(j)) blocked_q[j] <= 1'b1;
            if (state_q == APPLY && idx_q == 8'(j)) begin
               route_en_q[j]  <= en_q;
               route_sel_q[j] <= sel_q;
               blocked_q[j]   <= 1'b0;
            end
         end
      end
   end

   assign cfg_tready = state_q == IDLE;
   assign cfg_busy   = state_q != IDLE;
   assign cfg_err    = err_q;
endmodule

// File: tb/tb_sfa_xbar_switch.sv
// tb_sfa_xbar_switch: scoreboard bench for sfa_xbar_switch.
module tb_sfa_xbar_switch;
   localparam int DW = 32;
   localparam int NI = 4;
   localparam int NO = 4;

   logic             ACLK = 1'b0;
   logic             ARESETN;
   logic [NI-1:0]    s_tvalid;
   logic [NI-1:0]    s_tready;
   logic [NI*DW-1:0] s_tdata;
   logic [NO-1:0]    m_tvalid;
   logic [NO-1:0]    m_tready;
   logic [NO*DW-1:0] m_tdata;
   logic             cfg_tvalid;
   logic             cfg_tready;
   logic [31:0]      cfg_tdata;
   logic             cfg_busy;
   logic             cfg_err;

   sfa_xbar_switch #(.DATA_W(DW), .N_IN(NI), .N_OUT(NO), .SEL_W(2)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .cfg_tdata(cfg_tdata),
      .cfg_busy(cfg_busy), .cfg_err(cfg_err)
   );

   always #5 ACLK = ~ACLK;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [31:0] in_q [NI][$];
   logic [31:0] exp_q [NO][$];
   bit          hold [NI];
   int          rdy_mode [NO];
   bit          gap;
   bit          m_en [NO];
   int          m_sel [NO];
   bit          pend, pen, exp_err, cfg_req;
   int          pidx, psel;
   logic [31:0] cfg_word;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < NI; i++) begin in_q[i].delete(); hold[i] = 0; end
      for (int j = 0; j < NO; j++) begin exp_q[j].delete(); m_en[j] = 0; m_sel[j] = 0; end
      pend = 0; exp_err = 0; cfg_req = 0;
   endtask

   task automatic step();
      logic [NI-1:0] shs;
      logic [NO-1:0] mhs;
      logic          chs;
      @(negedge ACLK);
      for (int i = 0; i < NI; i++)
         if (!hold[i]) begin
            if (in_q[i].size() > 0 && (!gap || $urandom_range(0, 3) != 0)) begin
               s_tvalid[i] = 1'b1;
               s_tdata[i*DW +: DW] = in_q[i][0];
               hold[i] = 1;
            end else
               s_tvalid[i] = 1'b0;
         end
      for (int j = 0; j < NO; j++)
         m_tready[j] = rdy_mode[j] == 2 ? ($urandom_range(0, 3) != 0) :
                       rdy_mode[j] == 3 ? (cyc % 2 == 1) : (rdy_mode[j] == 1);
      cfg_tvalid = cfg_req;
      cfg_tdata  = cfg_word;
      #1;
      if (pend && !cfg_busy) begin
         m_en[pidx] = pen; m_sel[pidx] = psel; pend = 0;
      end
      for (int j = 0; j < NO; j++) begin
         chk("m_tvalid", m_tvalid[j], exp_q[j].size() != 0);
         if (exp_q[j].size() != 0) chk("m_tdata", m_tdata[j*DW +: DW], exp_q[j][0]);
      end
      for (int i = 0; i < NI; i++) begin
         bit has = 0, ok = 1;
         for (int j = 0; j < NO; j++)
            if (m_en[j] && m_sel[j] == i) begin
               has = 1;
               if (exp_q[j].size() >= 2 || (pend && pidx == j)) ok = 0;
            end
         chk("s_tready", s_tready[i], has && ok);
      end
      chk("cfg_tready", cfg_tready, !pend);
      chk("cfg_busy", cfg_busy, pend);
      chk("cfg_err", cfg_err, exp_err);
      shs = s_tvalid & s_tready;
      mhs = m_tvalid & m_tready;
      chs = cfg_tvalid & cfg_tready;
      @(posedge ACLK);
      cyc++;
      for (int j = 0; j < NO; j++)
         if (mhs[j] && exp_q[j].size() != 0) void'(exp_q[j].pop_front());
      for (int i = 0; i < NI; i++)
         if (shs[i] && in_q[i].size() != 0) begin
            logic [31:0] d = in_q[i].pop_front();
            hold[i] = 0;
            for (int j = 0; j < NO; j++)
               if (m_en[j] && m_sel[j] == i) exp_q[j].push_back(d);
         end
      if (chs) begin
         cfg_req = 0;
         if (int'(cfg_tdata[7:0]) < NO && int'(cfg_tdata[15:8]) < NI) begin
            pend = 1; pidx = int'(cfg_tdata[7:0]); psel = int'(cfg_tdata[15:8]); pen = cfg_tdata[16];
         end else
            exp_err = 1;
      end
   endtask

   task automatic cfg(input logic [31:0] w);
      int n = 0;
      cfg_req = 1; cfg_word = w;
      while ((cfg_req || pend) && n < 300) begin step(); n++; end
      chk("cfg_done", !(cfg_req || pend), 1);
   endtask

   task automatic wait_all();
      int  n = 0;
      bit  busy = 1;
      while (busy && n < 500) begin
         busy = 0;
         for (int i = 0; i < NI; i++) if (in_q[i].size() != 0) busy = 1;
         for (int j = 0; j < NO; j++) if (exp_q[j].size() != 0) busy = 1;
         if (busy) begin step(); n++; end
      end
      chk("drain_done", busy, 0);
   endtask

   task automatic flush(input int i);
      in_q[i].delete(); hold[i] = 0;
   endtask

   initial begin
      ARESETN = 1'b0; s_tvalid = '0; s_tdata = '0; m_tready = '0;
      cfg_tvalid = 1'b0; cfg_tdata = '0; cfg_word = '0; gap = 0;
      reset_model();
      for (int j = 0; j < NO; j++) rdy_mode[j] = 1;
      #12;
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_cfg_busy", cfg_busy, 0);
      chk("rst_cfg_err", cfg_err, 0);
      @(negedge ACLK); ARESETN = 1'b1;

      // single route, back-to-back stream
      cfg(32'h0001_0100);
      for (int k = 1; k <= 4; k++) in_q[1].push_back(32'hA5A5_0000 + k);
      wait_all();

      // broadcast from in 3 with one stalled consumer
      cfg(32'h0001_0300);
      cfg(32'h0001_0302);
      rdy_mode[2] = 0;
      for (int k = 0; k < 6; k++) in_q[3].push_back($urandom);
      repeat (6) step();
      rdy_mode[2] = 1;
      wait_all();

      // reconfigure out 1 under load
      rdy_mode[1] = 3; gap = 1;
      cfg(32'h0001_0001);
      for (int k = 0; k < 10; k++) in_q[0].push_back($urandom);
      for (int k = 0; k < 6; k++) in_q[2].push_back($urandom);
      repeat (4) step();
      cfg(32'h0001_0201);
      flush(0);
      wait_all();

      // out-of-range words then a valid one
      cfg(32'h0001_0004);
      cfg(32'h0001_0401);
      cfg(32'h0001_0002);

      // unrouted input
      cfg(32'h0000_0201);
      in_q[2].push_back(32'h1234_5678);
      repeat (20) step();
      flush(2);

      // random configs and traffic
      for (int j = 0; j < NO; j++) rdy_mode[j] = 2;
      for (int k = 0; k < 8; k++) begin
         cfg({15'd0, 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, NI-1)), 8'($urandom_range(0, NO-1))});
         for (int i = 0; i < NI; i++) repeat (4) in_q[i].push_back($urandom);
         repeat (15) step();
      end
      for (int i = 0; i < NI; i++) flush(i);
      wait_all();

      // asynchronous reset with out 0 full
      cfg(32'h0001_0100);
      rdy_mode[0] = 0; gap = 0;
      for (int k = 0; k < 3; k++) in_q[1].push_back($urandom);
      repeat (4) step();
      @(negedge ACLK); #2;
      ARESETN = 1'b0;
      #1;
      chk("arst_m_tvalid", m_tvalid, 0);
      chk("arst_s_tready", s_tready, 0);
      chk("arst_m_tdata", m_tdata, 0);
      chk("arst_cfg_busy", cfg_busy, 0);
      reset_model();
      s_tvalid = '0; cfg_tvalid = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK); ARESETN = 1'b1;
      rdy_mode[0] = 1;
      in_q[1].push_back(32'hDEAD_BEEF);
      repeat (3) step();
      flush(1);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
